// File: rtl/sram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sram_arb_pkg
// Shared definitions for the two-master SRAM arbiter:
//   state_t      - arbiter FSM encoding (ST_IDLE = 0, ST_BUSY = 1)
//   M0, M1       - master index constants used for grant / owner / last-grant
//   other_master - returns the index of the opposite master
// -----------------------------------------------------------------------------
package sram_arb_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,   // no transfer in flight, grant is combinational
      ST_BUSY = 1'b1    // slave stalled a transfer, owner is locked
   } state_t;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   function automatic logic other_master(input logic idx);
      return ~idx;
   endfunction

endpackage

// File: rtl/arb_rr2.sv
// -----------------------------------------------------------------------------
// arb_rr2
// Two-input arbiter used by sram_arbiter_2m while no transfer is in flight.
// Default build: round-robin. When both inputs request, the master that was
// NOT granted on the last completion wins; a sole requester always wins.
// The last-grant register resets to M1 so that M0 wins the first contention.
//
// Optional feature (macro ARB_FIXED_PRIO_EN): fixed priority, M0 always wins
// contention and the last-grant register does not exist.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   i_req0/1     - current requests of master 0 / 1
//   i_upd        - a transfer completes this cycle (update last-grant)
//   i_upd_idx    - index of the master whose transfer completes
//   o_gnt_vld    - at least one master is requesting
//   o_gnt_idx    - index of the winning master (meaningful when o_gnt_vld)
// -----------------------------------------------------------------------------
module arb_rr2
   import sram_arb_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_upd,
   input  logic i_upd_idx,
   output logic o_gnt_vld,
   output logic o_gnt_idx
);

`ifdef ARB_FIXED_PRIO_EN

   // No history is kept in this build; the update inputs and clocking are
   // intentionally left without a load.
   logic w_unused;
   assign w_unused = &{1'b0, clk, rst_n, i_upd, i_upd_idx};

   always_comb begin
      o_gnt_vld = i_req0 | i_req1;
      o_gnt_idx = i_req0 ? M0 : M1;
   end

`else

   logic r_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= M1;
      end else if (i_upd) begin
         r_last <= i_upd_idx;
      end
   end

   always_comb begin
      o_gnt_vld = i_req0 | i_req1;
      o_gnt_idx = M0;
      if (i_req0 && i_req1) begin
         o_gnt_idx = other_master(r_last);
      end else if (i_req1) begin
         o_gnt_idx = M1;
      end
   end

`endif

endmodule

// File: rtl/sram_arbiter_2m.sv
// -----------------------------------------------------------------------------
// sram_arbiter_2m
// Shares one SRAM controller port between two masters.
//
// Handshake: a master raises mN_ce with its fields and holds them until it
// sees mN_wait low in the same cycle; that cycle is the completion (s_ce=1,
// s_wait=0 for that master). Read data on s_q is valid on the cycle after a
// read completion and is broadcast on both mN_rdata buses; only the master
// whose read completed consumes it.
//
// FSM: ST_IDLE grants combinationally from the current requests (zero added
// latency). If the slave stalls (s_wait=1) while s_ce=1, the FSM moves to
// ST_BUSY and locks the owner until the slave drops s_wait. If the owner
// drops its request while locked, s_ce falls to 0 and the FSM still waits
// for s_wait=0 before returning to ST_IDLE.
//
// Optional feature (macro ARB_FIXED_PRIO_EN): fixed-priority arbitration,
// see arb_rr2.
//
// Parameters: ADDR_W (word address width), DATA_W (data width, multiple of 8)
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   m0_* / m1_* (inputs)       - ce, wren, addr, byteena, wdata per master
//   m0_wait / m1_wait          - stall to each master
//   m0_rdata / m1_rdata        - read data (both equal s_q)
//   s_ce, s_wren, s_addr,
//   s_byteena, s_wdata         - request to the SRAM controller
//   s_wait, s_q                - controller busy and read data
//   o_dbg_state                - current FSM state (0 = IDLE, 1 = BUSY)
// -----------------------------------------------------------------------------
module sram_arbiter_2m
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,

   input  logic                  m0_ce,
   input  logic                  m0_wren,
   input  logic [ADDR_W-1:0]     m0_addr,
   input  logic [DATA_W/8-1:0]   m0_byteena,
   input  logic [DATA_W-1:0]     m0_wdata,
   output logic                  m0_wait,
   output logic [DATA_W-1:0]     m0_rdata,

   input  logic                  m1_ce,
   input  logic                  m1_wren,
   input  logic [ADDR_W-1:0]     m1_addr,
   input  logic [DATA_W/8-1:0]   m1_byteena,
   input  logic [DATA_W-1:0]     m1_wdata,
   output logic                  m1_wait,
   output logic [DATA_W-1:0]     m1_rdata,

   output logic                  s_ce,
   output logic                  s_wren,
   output logic [ADDR_W-1:0]     s_addr,
   output logic [DATA_W/8-1:0]   s_byteena,
   output logic [DATA_W-1:0]     s_wdata,
   input  logic                  s_wait,
   input  logic [DATA_W-1:0]     s_q,

   output logic                  o_dbg_state
);

   state_t r_state;
   state_t w_state_nxt;
   logic   r_owner;

   logic   w_arb_vld;
   logic   w_arb_idx;
   logic   w_gnt_vld;
   logic   w_gnt_idx;
   logic   w_done;
   logic   w_lock;

   arb_rr2 u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_req0    (m0_ce),
      .i_req1    (m1_ce),
      .i_upd     (w_done),
      .i_upd_idx (w_gnt_idx),
      .o_gnt_vld (w_arb_vld),
      .o_gnt_idx (w_arb_idx)
   );

   // ---------------------------------------------------------------------
   // FSM state register and owner lock
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_owner <= M0;
      end else if (w_lock) begin
         r_owner <= w_gnt_idx;
      end
   end

   // ---------------------------------------------------------------------
   // Next state and grant selection
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_gnt_vld   = 1'b0;
      w_gnt_idx   = M0;
      w_lock      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_gnt_vld = w_arb_vld;
            w_gnt_idx = w_arb_idx;
            if (w_gnt_vld && s_wait) begin
               w_lock      = 1'b1;
               w_state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // The other master is ignored; if the owner withdraws, s_ce
            // simply drops and we still wait for the slave to go idle.
            w_gnt_idx = r_owner;
            w_gnt_vld = (r_owner == M1) ? m1_ce : m0_ce;
            if (!s_wait) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign w_done = w_gnt_vld & ~s_wait;

   // ---------------------------------------------------------------------
   // Slave-side request mux
   // ---------------------------------------------------------------------
   always_comb begin
      s_ce      = w_gnt_vld;
      s_wren    = m0_wren;
      s_addr    = m0_addr;
      s_byteena = m0_byteena;
      s_wdata   = m0_wdata;
      if (w_gnt_idx == M1) begin
         s_wren    = m1_wren;
         s_addr    = m1_addr;
         s_byteena = m1_byteena;
         s_wdata   = m1_wdata;
      end
   end

   // ---------------------------------------------------------------------
   // Master-side returns
   // ---------------------------------------------------------------------
   assign m0_wait  = m0_ce & ~(w_gnt_vld & (w_gnt_idx == M0) & ~s_wait);
   assign m1_wait  = m1_ce & ~(w_gnt_vld & (w_gnt_idx == M1) & ~s_wait);

   assign m0_rdata = s_q;
   assign m1_rdata = s_q;

   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sram_arbiter_2m.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter_2m
// Directed scenarios with literal expectations, then randomized traffic.
// A reference model (grant rules + reference memory) checks every cycle.
// -----------------------------------------------------------------------------
module tb_sram_arbiter_2m;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 32;
   localparam int BE_W   = DATA_W / 8;
   localparam int DEPTH  = 1 << ADDR_W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic              m0_ce = 0, m0_wren = 0, m1_ce = 0, m1_wren = 0;
   logic [ADDR_W-1:0] m0_addr = '0, m1_addr = '0;
   logic [BE_W-1:0]   m0_byteena = '0, m1_byteena = '0;
   logic [DATA_W-1:0] m0_wdata = '0, m1_wdata = '0;
   logic              m0_wait, m1_wait;
   logic [DATA_W-1:0] m0_rdata, m1_rdata;
   logic              s_ce, s_wren;
   logic [ADDR_W-1:0] s_addr;
   logic [BE_W-1:0]   s_byteena;
   logic [DATA_W-1:0] s_wdata;
   logic              s_wait = 1'b0;
   logic [DATA_W-1:0] s_q = '0;
   logic              dbg_state;

   sram_arbiter_2m #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_ce(m0_ce), .m0_wren(m0_wren), .m0_addr(m0_addr), .m0_byteena(m0_byteena),
      .m0_wdata(m0_wdata), .m0_wait(m0_wait), .m0_rdata(m0_rdata),
      .m1_ce(m1_ce), .m1_wren(m1_wren), .m1_addr(m1_addr), .m1_byteena(m1_byteena),
      .m1_wdata(m1_wdata), .m1_wait(m1_wait), .m1_rdata(m1_rdata),
      .s_ce(s_ce), .s_wren(s_wren), .s_addr(s_addr), .s_byteena(s_byteena),
      .s_wdata(s_wdata), .s_wait(s_wait), .s_q(s_q),
      .o_dbg_state(dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int n_tests = 0;
   int n_fail  = 0;

   logic [DATA_W-1:0] ref_mem   [DEPTH];
   logic [DATA_W-1:0] slave_mem [DEPTH];

   // model: is a stalled transfer locked, who owns it, who completed last
   bit                m_busy  = 0;
   bit                m_owner = 0;
   bit                m_last  = 1;
   bit                rd_pend [2];
   logic [DATA_W-1:0] rd_exp  [2];

   // observations handed from the compare process to the drivers
   bit                obs_rd = 0, obs_wr = 0;
   logic [ADDR_W-1:0] obs_addr = '0;
   logic [BE_W-1:0]   obs_be = '0;
   logic [DATA_W-1:0] obs_wdata = '0;
   bit                mst_done [2];

   function automatic logic [DATA_W-1:0] init_word(input int a);
      return 32'hC0DE_0000 | DATA_W'(a);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model + per-cycle compare ----------------
   bit                c_ce [2];
   bit                c_wr [2];
   logic [ADDR_W-1:0] c_ad [2];
   logic [BE_W-1:0]   c_be [2];
   logic [DATA_W-1:0] c_wd [2];
   bit                c_gv, c_g;

   always @(negedge clk) begin : model_cmp
      c_ce[0] = m0_ce;   c_ce[1] = m1_ce;
      c_wr[0] = m0_wren; c_wr[1] = m1_wren;
      c_ad[0] = m0_addr; c_ad[1] = m1_addr;
      c_be[0] = m0_byteena; c_be[1] = m1_byteena;
      c_wd[0] = m0_wdata;   c_wd[1] = m1_wdata;

      if (!rst_n) begin
         m_busy = 0; m_last = 1; rd_pend[0] = 0; rd_pend[1] = 0;
      end

      // who should be on the slave port this cycle
      if (m_busy) begin
         c_g  = m_owner;
         c_gv = c_ce[m_owner];
      end else if (c_ce[0] && c_ce[1]) begin
         c_gv = 1;
`ifdef ARB_FIXED_PRIO_EN
         c_g = 0;
`else
         c_g = !m_last;
`endif
      end else begin
         c_gv = c_ce[0] || c_ce[1];
         c_g  = c_ce[1] && !c_ce[0];
      end

      chk("s_ce", 64'(s_ce), 64'(c_gv));
      if (c_gv) begin
         chk("s_wren",    64'(s_wren),    64'(c_wr[c_g]));
         chk("s_addr",    64'(s_addr),    64'(c_ad[c_g]));
         chk("s_byteena", 64'(s_byteena), 64'(c_be[c_g]));
         chk("s_wdata",   64'(s_wdata),   64'(c_wd[c_g]));
      end
      chk("m0_wait", 64'(m0_wait), 64'(c_ce[0] && !(c_gv && c_g == 0 && !s_wait)));
      chk("m1_wait", 64'(m1_wait), 64'(c_ce[1] && !(c_gv && c_g == 1 && !s_wait)));
      chk("state",   64'(dbg_state), 64'(m_busy));
      if (rd_pend[0]) chk("m0_rdata", 64'(m0_rdata), 64'(rd_exp[0]));
      if (rd_pend[1]) chk("m1_rdata", 64'(m1_rdata), 64'(rd_exp[1]));

      // what the slave and the masters see happen (from the DUT pins)
      obs_rd      = rst_n && s_ce && !s_wait && !s_wren;
      obs_wr      = rst_n && s_ce && !s_wait && s_wren;
      obs_addr    = s_addr;
      obs_be      = s_byteena;
      obs_wdata   = s_wdata;
      mst_done[0] = rst_n && m0_ce && !m0_wait;
      mst_done[1] = rst_n && m1_ce && !m1_wait;

      // advance model to the next cycle
      rd_pend[0] = 0; rd_pend[1] = 0;
      if (rst_n) begin
         if (c_gv && !s_wait) begin
            m_last = c_g;
            if (!c_wr[c_g]) begin
               rd_pend[c_g] = 1;
               rd_exp[c_g]  = ref_mem[c_ad[c_g]];
            end else begin
               for (int b = 0; b < BE_W; b++)
                  if (c_be[c_g][b]) ref_mem[c_ad[c_g]][8*b +: 8] = c_wd[c_g][8*b +: 8];
            end
         end
         if (m_busy) begin
            if (!s_wait) m_busy = 0;
         end else if (c_gv && s_wait) begin
            m_busy  = 1;
            m_owner = c_g;
         end
      end
   end

   // ---------------- SRAM controller model (drives s_q) ----------------
   initial begin
      forever begin
         @(posedge clk); #1;
         if (obs_wr) begin
            for (int b = 0; b < BE_W; b++)
               if (obs_be[b]) slave_mem[obs_addr][8*b +: 8] = obs_wdata[8*b +: 8];
         end
         if (obs_rd) s_q = slave_mem[obs_addr];
         else        s_q = $urandom;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic nsamp();
      @(negedge clk);
   endtask

   task automatic set_m(input int n, input bit ce, input bit wr, input logic [ADDR_W-1:0] a,
                        input logic [BE_W-1:0] be, input logic [DATA_W-1:0] wd);
      if (n == 0) begin
         m0_ce = ce; m0_wren = wr; m0_addr = a; m0_byteena = be; m0_wdata = wd;
      end else begin
         m1_ce = ce; m1_wren = wr; m1_addr = a; m1_byteena = be; m1_wdata = wd;
      end
   endtask

   task automatic do_reset();
      tick();
      rst_n = 0; m0_ce = 0; m1_ce = 0; s_wait = 0;
      nsamp();
      chk("rst_state", 64'(dbg_state), 64'd0);
      chk("rst_s_ce",  64'(s_ce),      64'd0);
      tick();
      rst_n = 1;
      nsamp();
   endtask

   // ---------------- stimulus ----------------
   logic [ADDR_W-1:0] rr_exp [4];
   bit                act [2];

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         ref_mem[i]   = init_word(i);
         slave_mem[i] = init_word(i);
      end
      mst_done[0] = 0; mst_done[1] = 0;
      rd_pend[0] = 0;  rd_pend[1] = 0;
      nsamp();
      chk("reset_state", 64'(dbg_state), 64'd0);
      chk("reset_m0_wait", 64'(m0_wait), 64'd0);
      tick();
      rst_n = 1;

      // single read stalled 3 cycles
      do_reset();
      tick(); set_m(0, 1, 0, 9'h010, 4'hF, 0); s_wait = 1;
      nsamp(); chk("rd_wait0", 64'(m0_wait), 1); chk("rd_addr0", 64'(s_addr), 64'h010);
      repeat (2) begin
         tick(); nsamp();
         chk("rd_wait", 64'(m0_wait), 1); chk("rd_addr", 64'(s_addr), 64'h010);
         chk("rd_busy", 64'(dbg_state), 1);
      end
      tick(); s_wait = 0;
      nsamp(); chk("rd_done_wait", 64'(m0_wait), 0); chk("rd_done_addr", 64'(s_addr), 64'h010);
      tick(); m0_ce = 0;
      nsamp(); chk("rd_data", 64'(m0_rdata), 64'hC0DE_0010);

      // contention straight after reset
      do_reset();
      tick(); set_m(0, 1, 0, 9'h020, 4'hF, 0); set_m(1, 1, 0, 9'h030, 4'hF, 0); s_wait = 1;
      nsamp(); chk("ct_addr0", 64'(s_addr), 64'h020); chk("ct_m1_wait0", 64'(m1_wait), 1);
      tick(); s_wait = 0;
      nsamp(); chk("ct_m0_done", 64'(m0_wait), 0); chk("ct_m1_wait1", 64'(m1_wait), 1);
      tick(); m0_ce = 0;
      nsamp(); chk("ct_addr1", 64'(s_addr), 64'h030); chk("ct_m1_done", 64'(m1_wait), 0);
      chk("ct_m0_data", 64'(m0_rdata), 64'hC0DE_0020);
      tick(); m1_ce = 0;
      nsamp(); chk("ct_m1_data", 64'(m1_rdata), 64'hC0DE_0030);

      // continuous requests from both masters
`ifdef ARB_FIXED_PRIO_EN
      rr_exp[0] = 9'h040; rr_exp[1] = 9'h040; rr_exp[2] = 9'h040; rr_exp[3] = 9'h040;
`else
      rr_exp[0] = 9'h040; rr_exp[1] = 9'h041; rr_exp[2] = 9'h040; rr_exp[3] = 9'h041;
`endif
      do_reset();
      tick(); set_m(0, 1, 0, 9'h040, 4'hF, 0); set_m(1, 1, 0, 9'h041, 4'hF, 0); s_wait = 0;
      for (int i = 0; i < 4; i++) begin
         if (i != 0) tick();
         nsamp(); chk($sformatf("rr_order%0d", i), 64'(s_addr), 64'(rr_exp[i]));
      end
      tick(); m0_ce = 0; m1_ce = 0;

      // owner lock during a stalled write
      do_reset();
      tick(); set_m(1, 1, 1, 9'h1FF, 4'b0011, 32'hA5A5_5A5A); s_wait = 1;
      nsamp(); chk("lk_addr0", 64'(s_addr), 64'h1FF);
      tick(); set_m(0, 1, 0, 9'h001, 4'hF, 0);
      nsamp(); chk("lk_addr1", 64'(s_addr), 64'h1FF); chk("lk_wdata", 64'(s_wdata), 64'hA5A5_5A5A);
      chk("lk_be", 64'(s_byteena), 64'h3); chk("lk_wren", 64'(s_wren), 1); chk("lk_m0_wait", 64'(m0_wait), 1);
      tick();
      nsamp(); chk("lk_addr2", 64'(s_addr), 64'h1FF);
      tick(); s_wait = 0;
      nsamp(); chk("lk_addr3", 64'(s_addr), 64'h1FF); chk("lk_m1_done", 64'(m1_wait), 0);
      chk("lk_m0_held", 64'(m0_wait), 1);
      tick(); m1_ce = 0;
      nsamp(); chk("lk_m0_addr", 64'(s_addr), 64'h001); chk("lk_m0_done", 64'(m0_wait), 0);
      tick(); set_m(0, 1, 0, 9'h1FF, 4'hF, 0);
      nsamp(); chk("lk_rd1", 64'(m0_rdata), 64'hC0DE_0001);
      tick(); m0_ce = 0;
      nsamp(); chk("lk_merge", 64'(m0_rdata), 64'hC0DE_5A5A);

      // owner withdraws while locked
      do_reset();
      tick(); set_m(0, 1, 0, 9'h080, 4'hF, 0); s_wait = 1;
      nsamp();
      tick(); m0_ce = 0; set_m(1, 1, 0, 9'h090, 4'hF, 0);
      nsamp(); chk("pv_s_ce", 64'(s_ce), 0); chk("pv_busy", 64'(dbg_state), 1);
      chk("pv_m1_wait", 64'(m1_wait), 1);
      tick(); s_wait = 0;
      nsamp(); chk("pv_s_ce2", 64'(s_ce), 0); chk("pv_m1_wait2", 64'(m1_wait), 1);
      tick();
      nsamp(); chk("pv_idle", 64'(dbg_state), 0); chk("pv_m1_addr", 64'(s_addr), 64'h090);
      chk("pv_m1_done", 64'(m1_wait), 0);
      tick(); m1_ce = 0;

      // reset while m1 owns a stalled transfer, last grant was m0
      do_reset();
      tick(); set_m(0, 1, 0, 9'h050, 4'hF, 0); s_wait = 0;
      nsamp(); chk("rs_m0_done", 64'(m0_wait), 0);
      tick(); m0_ce = 0; set_m(1, 1, 0, 9'h060, 4'hF, 0); s_wait = 1;
      nsamp();
      tick();
      nsamp(); chk("rs_busy", 64'(dbg_state), 1);
      tick(); rst_n = 0; m1_ce = 0;
      nsamp(); chk("rs_idle", 64'(dbg_state), 0); chk("rs_s_ce", 64'(s_ce), 0);
      tick(); rst_n = 1; set_m(0, 1, 0, 9'h070, 4'hF, 0); set_m(1, 1, 0, 9'h060, 4'hF, 0); s_wait = 0;
      nsamp(); chk("rs_m0_wins", 64'(s_addr), 64'h070); chk("rs_m1_wait", 64'(m1_wait), 1);
      tick(); m0_ce = 0;
      nsamp();
      tick(); m1_ce = 0;

      // zero-wait slave, alternating single requests
      do_reset();
      for (int i = 0; i < 6; i++) begin
         tick(); s_wait = 0;
         set_m(i % 2, 1, i[1], ADDR_W'(i + 8), 4'hF, $urandom);
         set_m(1 - (i % 2), 0, 0, 0, 0, 0);
         nsamp();
         chk($sformatf("zw_m0_wait%0d", i), 64'(m0_wait), 0);
         chk($sformatf("zw_m1_wait%0d", i), 64'(m1_wait), 0);
      end
      tick(); m0_ce = 0; m1_ce = 0;
      nsamp();

      // randomized traffic
      act[0] = 0; act[1] = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick();
         s_wait = ($urandom_range(0, 99) < 45);
         if (cyc == 1500) begin
            rst_n = 0; act[0] = 0; act[1] = 0; m0_ce = 0; m1_ce = 0;
         end else begin
            rst_n = 1;
            for (int n = 0; n < 2; n++) begin
               if (act[n] && mst_done[n]) act[n] = 0;
               if (!act[n] && $urandom_range(0, 99) < 50) begin
                  act[n] = 1;
                  set_m(n, 1, $urandom_range(0, 1), ADDR_W'($urandom_range(0, 15)),
                        BE_W'($urandom), $urandom);
               end else if (!act[n]) begin
                  if (n == 0) m0_ce = 0; else m1_ce = 0;
               end
            end
         end
      end
      tick(); m0_ce = 0; m1_ce = 0; s_wait = 0;
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
